reg_bank_arbiter: RTL
=====================

// Module: reg_bank_arbiter
// PURPOSE
//  Shares one bank of 8-bit registers among NREQ requesters via round-robin arbitration.
//  Each requester raises req with a read/write access; the block grants one owner per cycle.
//  Optional lock lets an owner keep the grant for short bursts.
//  Sits between the datapath clients and the register bank; the bank lives inside this block.
// PARAMETERS
//  NREQ      4   number of requesters (2..8)
//  AW        3   register address width; bank depth = 2**AW
//  DW        8   register data width
//  MAX_HOLD  4   max consecutive grants to one locked owner (>=1)
// PORTS
//  clk      in   1          clock, all state on posedge
//  rst      in   1          asynchronous, active-low reset
//  req      in   NREQ       access request, one bit per requester
//  lock     in   NREQ       keep grant after this access (burst)
//  wr       in   NREQ       1 = write, 0 = read, per requester
//  addr     in   NREQ*AW    flat address bus, requester i at [i*AW +: AW]
//  wdata    in   NREQ*DW    flat write data, requester i at [i*DW +: DW]
//  gnt      out  NREQ       one-hot registered grant (all-zero when idle)
//  owner    out  clog2(NREQ) index of current grant holder
//  rdata    out  DW         read data
//  rvalid   out  1          rdata valid, one-cycle pulse
//  busy     out  1          1 whenever gnt != 0
// BEHAVIOUR
//  Reset (rst=0, async): gnt=0, owner=0, rdata=0, rvalid=0, busy=0, all bank regs=0,
//    rr pointer=0, hold_cnt=0, FSM=IDLE.
//  FSM: IDLE (no grant), GRANT (first access of an owner), LOCKED (burst continuation).
//  Arbitration: search req starting at (last owner + 1) mod NREQ; after reset search starts at 0.
//    The previous owner may win again only if it is the sole requester.
//  Latency: req seen high at edge t -> gnt one-hot valid after edge t.
//  Access: happens in a cycle with gnt[i] & req[i], using addr/wr/wdata of i sampled that cycle.
//    Write: bank[addr] updated at the closing edge.
//    Read: rdata = bank[addr] and rvalid=1 for the following cycle.
//  gnt[i] high but req[i] low: no access; grant released at next edge.
//  Next-state at each edge from GRANT/LOCKED:
//    lock[owner] & req[owner] & hold_cnt < MAX_HOLD-1 -> LOCKED, same owner, hold_cnt++.
//    Else any req -> GRANT to round-robin winner, hold_cnt=0, no dead cycle.
//    Else -> IDLE, gnt=0.
//  MAX_HOLD=1: lock has no effect.
//  Read-after-write to the same address in consecutive cycles: read returns the new value.
//  rvalid is low for writes and idle cycles. rdata holds its last value when rvalid=0.
//  Reset asserted mid-burst aborts immediately. A write whose closing edge coincides with
//    reset assertion is lost.
// CONFIGURATION
//  ARB_STATS_EN defined:
//    Adds output grant_cnt [NREQ*8], per-requester 8-bit saturating count of granted accesses.
//    Counters hold at 255 and clear on reset.
//  ARB_STATS_EN undefined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package reg_bank_pkg: FSM state encoding (IDLE/GRANT/LOCKED), default AW/DW.
//  Sub-module rr_pick: combinational round-robin selector.
//    Inputs: req vector, start pointer. Outputs: one-hot winner, index, any-valid.
//  FSM, hold counter, bank array and read register stay in reg_bank_arbiter.
// TESTING
//  1. Reset: drive rst=0 mid-run -> all outputs 0 at once; after release, read of addr 5 returns 8'h00.
//  2. Single write/read: req[2],wr,addr=3,wdata=8'hA5.
//     Then req[2] read addr=3 -> rdata=8'hA5, rvalid=1 one cycle later.
//  3. Round-robin: req=4'b1111 held, lock=0 -> gnt cycles 0001,0010,0100,1000,0001; no idle cycles.
//  4. Lock burst: MAX_HOLD=4, req[1]&lock[1] with req[3] pending.
//     -> gnt[1] for exactly 4 cycles, then gnt[3].
//  5. Drop while granted: req[0] falls in its grant cycle -> no write; bank unchanged; next requester granted.
//  6. ARB_STATS_EN: 300 grants to requester 0 -> grant_cnt[7:0]=8'd255, other counts correct.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register-bank arbiter.
//  - FSM state encoding (IDLE / GRANT / LOCKED)
//  - default address / data widths of the bank
//  - rr_next: round-robin pointer advance helper
package reg_bank_pkg;

  localparam int DEF_AW = 3;
  localparam int DEF_DW = 8;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE   = 2'd0;  // no grant outstanding
  localparam arb_state_t ST_GRANT  = 2'd1;  // first access of a new owner
  localparam arb_state_t ST_LOCKED = 2'd2;  // burst continuation of the same owner

  // Index that follows idx in a ring of n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Scans req starting at index start and wrapping around; the first set bit wins.
// Ports:
//   req    in  N    request vector
//   start  in  IW   index where the search begins
//   onehot out N    one-hot winner (zero when no request)
//   idx    out IW   binary index of the winner (zero when no request)
//   any    out 1    at least one request present
module rr_pick
  import reg_bank_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    logic [IW-1:0] j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(start) + k) % N);
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = j;
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter in front of an internal bank of DW-bit registers.
// One requester owns the bank per cycle; a locked owner may keep it for up to
// MAX_HOLD consecutive grants.
// Optional feature macro: ARB_STATS_EN adds grant_cnt (per-requester 8-bit
// saturating count of granted accesses).
// Handshake: an access takes place in any cycle where gnt[i] & req[i] are both
// high, using addr/wr/wdata of requester i from that cycle. A write lands at the
// closing edge; a read returns rdata with a one-cycle rvalid pulse in the next
// cycle. gnt without req is simply a wasted slot.
// Ports:
//   clk        in   clock, all state on posedge
//   rst        in   asynchronous active-low reset
//   req/lock/wr in  NREQ     per-requester request, burst lock, write select
//   addr       in   NREQ*AW  flat address bus
//   wdata      in   NREQ*DW  flat write-data bus
//   gnt        out  NREQ     registered one-hot grant
//   owner      out  OW       index of current (or last) grant holder
//   rdata      out  DW       read data, held when rvalid is low
//   rvalid     out  1        read-data valid pulse
//   busy       out  1        any grant outstanding
//   grant_cnt  out  NREQ*8   (ARB_STATS_EN only) access counters
//   dbg_state  out  2        FSM state for observation
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int MAX_HOLD = 4,
  parameter int OW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    lock,
  input  logic [NREQ-1:0]    wr,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [OW-1:0]      owner,
  output logic [DW-1:0]      rdata,
  output logic               rvalid,
  output logic               busy,
`ifdef ARB_STATS_EN
  output logic [NREQ*8-1:0]  grant_cnt,
`endif
  output arb_state_t         dbg_state
);

  localparam int HW = $clog2(MAX_HOLD) + 1;

  arb_state_t        state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     ptr_q, ptr_d;     // where the next round-robin search starts
  logic [HW-1:0]     hold_q, hold_d;   // grants already given within the current burst
  logic [DW-1:0]     rdata_q;
  logic              rvalid_q;
  logic [DW-1:0]     bank_q [2**AW];

  logic [NREQ-1:0]   pick_oh;
  logic [OW-1:0]     pick_idx;
  logic              pick_any;

  logic              acc_req;
  logic              acc_wr;
  logic [AW-1:0]     acc_addr;
  logic [DW-1:0]     acc_wdata;
  logic              acc;
  logic              keep;

  // Searching from last owner + 1 puts the previous owner last in line, so it
  // only wins again when nobody else is asking.
  rr_pick #(.N(NREQ), .IW(OW)) u_pick (
    .req    (req),
    .start  (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Mux the owner's access fields.
  always_comb begin
    acc_req   = 1'b0;
    acc_wr    = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == OW'(i)) begin
        acc_req   = req[i];
        acc_wr    = wr[i];
        acc_addr  = addr[i*AW +: AW];
        acc_wdata = wdata[i*DW +: DW];
      end
    end
  end

  assign acc  = (gnt_q != '0) && acc_req;
  assign keep = (state_q != ST_IDLE) && acc_req && (lock & gnt_q) != '0
                && (int'(hold_q) < MAX_HOLD - 1);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    if (keep) begin
      state_d = ST_LOCKED;
      hold_d  = hold_q + HW'(1);
    end else if (pick_any) begin
      state_d = ST_GRANT;
      gnt_d   = pick_oh;
      owner_d = pick_idx;
      ptr_d   = OW'(rr_next(int'(pick_idx), NREQ));
      hold_d  = '0;
    end else begin
      state_d = ST_IDLE;
      gnt_d   = '0;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      hold_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      for (int a = 0; a < 2**AW; a++) bank_q[a] <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      rvalid_q <= acc && !acc_wr;
      if (acc && !acc_wr) rdata_q <= bank_q[acc_addr];
      if (acc && acc_wr)  bank_q[acc_addr] <= acc_wdata;
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign busy      = (gnt_q != '0);
  assign dbg_state = state_q;

`ifdef ARB_STATS_EN
  logic [7:0] cnt_q [NREQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_q[i] && req[i] && cnt_q[i] != 8'hFF) cnt_q[i] <= cnt_q[i] + 8'd1;
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign grant_cnt[g*8 +: 8] = cnt_q[g];
  end
`endif

endmodule
